// File: rtl/sdram_arbiter_if.sv
// sdram_arbiter_if: bundles everything that passes between the system bus
// requesters, the sdram controller and the arbiter.
//   ready            sdram initialisation done
//   p0*/p1*          two requester ports: level Rd/Wr, address A, write
//                    data D, read data Q, one-cycle completion Ack
//   ramRefresh/Write/Read, ramA, ramD, ramQ
//                    strobes, address and data to/from the sdram controller
// Modport slave is the arbiter side; modport master is the environment
// (requesters plus controller).
interface sdram_arbiter_if;
  logic        ready;
  logic        p0Rd;
  logic        p0Wr;
  logic [23:0] p0A;
  logic [15:0] p0D;
  logic [15:0] p0Q;
  logic        p0Ack;
  logic        p1Rd;
  logic        p1Wr;
  logic [23:0] p1A;
  logic [15:0] p1D;
  logic [15:0] p1Q;
  logic        p1Ack;
  logic        ramRefresh;
  logic        ramWrite;
  logic        ramRead;
  logic [23:0] ramA;
  logic [15:0] ramD;
  logic [15:0] ramQ;

  modport slave (
    input  ready, p0Rd, p0Wr, p0A, p0D, p1Rd, p1Wr, p1A, p1D, ramQ,
    output p0Q, p0Ack, p1Q, p1Ack, ramRefresh, ramWrite, ramRead, ramA, ramD
  );

  modport master (
    output ready, p0Rd, p0Wr, p0A, p0D, p1Rd, p1Wr, p1A, p1D, ramQ,
    input  p0Q, p0Ack, p1Q, p1Ack, ramRefresh, ramWrite, ramRead, ramA, ramD
  );
endinterface

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares one sdram controller between two requester ports and
// an internal refresh scheduler. Each granted operation occupies a fixed slot
// of SLOT clocks; the controller has no busy output, so the slot timer is
// what spaces operations apart.
// Ports:
//   clock  system clock (same as the sdram controller)
//   reset  asynchronous, active-low
//   bus    sdram_arbiter_if.slave: requester ports and controller signals
module sdram_arbiter #(
  parameter int SLOT           = 16,
  parameter int REFRESH_PERIOD = 390
) (
  input logic            clock,
  input logic            reset,
  sdram_arbiter_if.slave bus
);

  localparam logic [4:0]  SC_LAST = 5'(SLOT - 1);
  localparam logic [4:0]  SC_PRE  = 5'(SLOT - 2);
  localparam logic [11:0] RF_LAST = 12'(REFRESH_PERIOD - 1);

  typedef enum logic { S_IDLE, S_SLOT } state_t;
  typedef enum logic [1:0] { OP_RD, OP_WR, OP_RF } op_t;

  state_t      state, state_n;
  logic [4:0]  sc, sc_n;
  op_t         op;
  logic        gnt;        // port id of the current slot
  logic        last;       // last granted port (refresh does not count)
  logic [11:0] rc;
  logic        rf_pending;
  logic [23:0] ram_a;
  logic [15:0] ram_d;
  logic [15:0] q0, q1;

  logic p0_req, p1_req, rf_set, rf_req;
  logic grant_rf, grant_p0, grant_p1;

  assign p0_req = bus.p0Rd | bus.p0Wr;
  assign p1_req = bus.p1Rd | bus.p1Wr;
  // A wrap in this very cycle already counts as pending so that it beats a
  // port request arriving at the same edge.
  assign rf_set = bus.ready && (rc == RF_LAST);
  assign rf_req = rf_pending | rf_set;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= S_IDLE;
      sc    <= 5'd0;
    end else begin
      state <= state_n;
      sc    <= sc_n;
    end
  end

  always_comb begin
    state_n  = state;
    sc_n     = sc;
    grant_rf = 1'b0;
    grant_p0 = 1'b0;
    grant_p1 = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.ready) begin
          if (rf_req)
            grant_rf = 1'b1;
          else if (p1_req && (!last || !p0_req))
            grant_p1 = 1'b1;
          else if (p0_req)
            grant_p0 = 1'b1;
          if (grant_rf || grant_p0 || grant_p1) begin
            state_n = S_SLOT;
            sc_n    = 5'd0;
          end
        end
      end
      S_SLOT: begin
        if (sc == SC_LAST) begin
          state_n = S_IDLE;
          sc_n    = 5'd0;
        end else begin
          sc_n = sc + 5'd1;
        end
      end
      default: begin
        state_n = S_IDLE;
        sc_n    = 5'd0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      op         <= OP_RD;
      gnt        <= 1'b0;
      last       <= 1'b1;
      rc         <= 12'd0;
      rf_pending <= 1'b0;
      ram_a      <= 24'd0;
      ram_d      <= 16'd0;
      q0         <= 16'd0;
      q1         <= 16'd0;
    end else begin
      if (grant_p0) begin
        ram_a <= bus.p0A;
        ram_d <= bus.p0D;
        op    <= bus.p0Wr ? OP_WR : OP_RD;
        gnt   <= 1'b0;
        last  <= 1'b0;
      end else if (grant_p1) begin
        ram_a <= bus.p1A;
        ram_d <= bus.p1D;
        op    <= bus.p1Wr ? OP_WR : OP_RD;
        gnt   <= 1'b1;
        last  <= 1'b1;
      end else if (grant_rf) begin
        op <= OP_RF;
      end

      // Capture read data on the edge into the last slot cycle so Q is
      // valid together with Ack.
      if (state == S_SLOT && sc == SC_PRE && op == OP_RD) begin
        if (gnt) q1 <= bus.ramQ;
        else     q0 <= bus.ramQ;
      end

      if (!bus.ready || rc == RF_LAST) rc <= 12'd0;
      else                             rc <= rc + 12'd1;

      rf_pending <= rf_req & ~grant_rf;
    end
  end

  logic strobe_on, ack_on;
  assign strobe_on = (state == S_SLOT) && (sc < 5'd2);
  assign ack_on    = (state == S_SLOT) && (sc == SC_LAST) && (op != OP_RF);

  assign bus.ramRead    = strobe_on && (op == OP_RD);
  assign bus.ramWrite   = strobe_on && (op == OP_WR);
  assign bus.ramRefresh = strobe_on && (op == OP_RF);
  assign bus.ramA       = ram_a;
  assign bus.ramD       = ram_d;
  assign bus.p0Q        = q0;
  assign bus.p1Q        = q1;
  assign bus.p0Ack      = ack_on && !gnt;
  assign bus.p1Ack      = ack_on && gnt;

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed bench for sdram_arbiter (SLOT=16,
// REFRESH_PERIOD=64). Single-port transactions come from a vector table;
// ready gating, refresh, async reset and contention are hand-written.
module tb_sdram_arbiter;
  localparam int SLOT = 16;
  localparam int RP   = 64;

  logic clock;
  logic reset;
  int   checks;
  int   errors;

  sdram_arbiter_if bus ();

  sdram_arbiter #(.SLOT(SLOT), .REFRESH_PERIOD(RP)) dut (
    .clock(clock),
    .reset(reset),
    .bus  (bus)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        port;
    logic        rd;
    logic        wr;
    logic [23:0] a;
    logic [15:0] d;
    logic [15:0] mem;
    logic        exp_rd;
    logic        exp_wr;
    logic [15:0] exp_q0;
    logic [15:0] exp_q1;
  } vec_t;

  vec_t vecs[6];

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic clear_reqs();
    bus.p0Rd = 1'b0; bus.p0Wr = 1'b0; bus.p0A = 24'd0; bus.p0D = 16'd0;
    bus.p1Rd = 1'b0; bus.p1Wr = 1'b0; bus.p1A = 24'd0; bus.p1D = 16'd0;
  endtask

  // Two cycles of ready=0 put the refresh counter back at 0.
  task automatic rearm();
    bus.ready = 1'b0;
    tick();
    tick();
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    rearm();
    bus.ready = 1'b1;
    bus.ramQ  = v.mem;
    if (v.port == 1'b0) begin
      bus.p0Rd = v.rd; bus.p0Wr = v.wr; bus.p0A = v.a; bus.p0D = v.d;
    end else begin
      bus.p1Rd = v.rd; bus.p1Wr = v.wr; bus.p1A = v.a; bus.p1D = v.d;
    end
    tick();
    for (int i = 0; i < SLOT; i++) begin
      check($sformatf("v%0d sc%0d ramRead", idx, i), bus.ramRead, v.exp_rd && (i < 2));
      check($sformatf("v%0d sc%0d ramWrite", idx, i), bus.ramWrite, v.exp_wr && (i < 2));
      check($sformatf("v%0d sc%0d ramRefresh", idx, i), bus.ramRefresh, 1'b0);
      check($sformatf("v%0d sc%0d ramA", idx, i), bus.ramA, v.a);
      check($sformatf("v%0d sc%0d ramD", idx, i), bus.ramD, v.d);
      check($sformatf("v%0d sc%0d p0Ack", idx, i), bus.p0Ack, (v.port == 1'b0) && (i == SLOT - 1));
      check($sformatf("v%0d sc%0d p1Ack", idx, i), bus.p1Ack, (v.port == 1'b1) && (i == SLOT - 1));
      if (i == SLOT - 1) begin
        check($sformatf("v%0d ack p0Q", idx), bus.p0Q, v.exp_q0);
        check($sformatf("v%0d ack p1Q", idx), bus.p1Q, v.exp_q1);
      end
      tick();
    end
    clear_reqs();
    check($sformatf("v%0d idle p0Ack", idx), bus.p0Ack, 1'b0);
    check($sformatf("v%0d idle p1Ack", idx), bus.p1Ack, 1'b0);
    tick();
    check($sformatf("v%0d no regrant", idx),
          {bus.ramRead, bus.ramWrite, bus.ramRefresh}, 3'b000);
    check($sformatf("v%0d hold p0Q", idx), bus.p0Q, v.exp_q0);
    check($sformatf("v%0d hold p1Q", idx), bus.p1Q, v.exp_q1);
  endtask

  initial begin
    int strobe_cnt, ack_cnt, ref_hi, nrise, rise1, rise2;
    int nacks;
    int ack_time[4];
    logic ack_port[4];
    logic prev_ref;

    checks = 0;
    errors = 0;

    vecs[0] = '{1'b0, 1'b1, 1'b0, 24'h012345, 16'h0000, 16'hBEEF, 1'b1, 1'b0, 16'hBEEF, 16'h0000};
    vecs[1] = '{1'b1, 1'b0, 1'b1, 24'h000100, 16'h5A5A, 16'hDEAD, 1'b0, 1'b1, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 24'hABCDEF, 16'h0001, 16'h1234, 1'b1, 1'b0, 16'hBEEF, 16'h1234};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 24'h000042, 16'hC3C3, 16'h7777, 1'b0, 1'b1, 16'hBEEF, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 1'b1, 24'hFFFFFF, 16'hFFFF, 16'h0000, 1'b0, 1'b1, 16'hBEEF, 16'h1234};
    vecs[5] = '{1'b1, 1'b1, 1'b0, 24'h800000, 16'h0000, 16'h0F0F, 1'b1, 1'b0, 16'hBEEF, 16'h0F0F};

    reset     = 1'b0;
    bus.ready = 1'b0;
    bus.ramQ  = 16'h0000;
    clear_reqs();
    tick();
    tick();
    check("reset strobes", {bus.ramRead, bus.ramWrite, bus.ramRefresh}, 3'b000);
    check("reset acks", {bus.p0Ack, bus.p1Ack}, 2'b00);
    check("reset ramA", bus.ramA, 24'd0);
    check("reset ramD", bus.ramD, 16'd0);
    check("reset p0Q", bus.p0Q, 16'd0);
    check("reset p1Q", bus.p1Q, 16'd0);
    reset = 1'b1;
    tick();

    for (int k = 0; k < 6; k++) run_vec(vecs[k], k);

    // ready gating: requests held for 200 cycles while ready=0
    bus.ready = 1'b0;
    bus.p0Rd = 1'b1; bus.p0A = 24'h00BEAD; bus.p0D = 16'h2222;
    bus.ramQ = 16'h4444;
    strobe_cnt = 0;
    ack_cnt = 0;
    for (int n = 0; n < 200; n++) begin
      tick();
      if (bus.ramRead || bus.ramWrite || bus.ramRefresh) strobe_cnt++;
      if (bus.p0Ack || bus.p1Ack) ack_cnt++;
    end
    check("gated strobes", strobe_cnt, 0);
    check("gated acks", ack_cnt, 0);
    bus.ready = 1'b1;
    tick();
    check("ungate ramRead", bus.ramRead, 1'b1);
    check("ungate ramRefresh", bus.ramRefresh, 1'b0);
    check("ungate ramA", bus.ramA, 24'h00BEAD);
    for (int n = 1; n < SLOT; n++) tick();
    check("ungate p0Ack", bus.p0Ack, 1'b1);
    check("ungate p0Q", bus.p0Q, 16'h4444);
    tick();
    clear_reqs();
    tick();

    // refresh scheduling, then refresh beating p0 at the wrap cycle
    rearm();
    bus.ready = 1'b1;
    ref_hi = 0; nrise = 0; rise1 = 0; rise2 = 0; ack_cnt = 0;
    prev_ref = 1'b0;
    for (int n = 1; n <= 230; n++) begin
      tick();
      if (n <= 140) begin
        if (bus.ramRefresh) ref_hi++;
        if (bus.ramRefresh && !prev_ref) begin
          nrise++;
          if (nrise == 1) rise1 = n;
          if (nrise == 2) rise2 = n;
        end
        if (bus.p0Ack || bus.p1Ack) ack_cnt++;
        prev_ref = bus.ramRefresh;
      end
      if (n == 191) begin
        bus.p0Rd = 1'b1; bus.p0A = 24'h13579B; bus.p0D = 16'h3333;
        bus.ramQ = 16'h6666;
      end
      if (n == 192) begin
        check("wrap ramRefresh", bus.ramRefresh, 1'b1);
        check("wrap ramRead", bus.ramRead, 1'b0);
        check("wrap ramA kept", bus.ramA, 24'h00BEAD);
      end
      if (n == 209) begin
        check("after rf ramRead", bus.ramRead, 1'b1);
        check("after rf ramA", bus.ramA, 24'h13579B);
      end
      if (n == 224) begin
        check("after rf p0Ack", bus.p0Ack, 1'b1);
        check("after rf p0Q", bus.p0Q, 16'h6666);
      end
      if (n == 225) clear_reqs();
    end
    check("refresh rises", nrise, 2);
    check("refresh first", rise1, 64);
    check("refresh second", rise2, 128);
    check("refresh high cycles", ref_hi, 4);
    check("refresh acks", ack_cnt, 0);

    // async reset in the middle of a read slot
    rearm();
    bus.ready = 1'b1;
    bus.p0Rd = 1'b1; bus.p0A = 24'h0A0B0C; bus.p0D = 16'h1111;
    bus.ramQ = 16'h9999;
    for (int n = 0; n < 6; n++) tick();
    check("pre-reset ramA", bus.ramA, 24'h0A0B0C);
    #2;
    reset = 1'b0;
    #1;
    check("async ramA", bus.ramA, 24'd0);
    check("async ramD", bus.ramD, 16'd0);
    check("async p0Q", bus.p0Q, 16'd0);
    check("async p1Q", bus.p1Q, 16'd0);
    check("async strobes", {bus.ramRead, bus.ramWrite, bus.ramRefresh}, 3'b000);
    clear_reqs();
    bus.ready = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    ack_cnt = 0;
    strobe_cnt = 0;
    for (int n = 0; n < 20; n++) begin
      tick();
      if (bus.p0Ack || bus.p1Ack) ack_cnt++;
      if (bus.ramRead || bus.ramWrite || bus.ramRefresh) strobe_cnt++;
    end
    check("abandoned acks", ack_cnt, 0);
    check("abandoned strobes", strobe_cnt, 0);

    // contention: both ports request continuously
    rearm();
    bus.ready = 1'b1;
    bus.p0Rd = 1'b1; bus.p0A = 24'h111111;
    bus.p1Rd = 1'b1; bus.p1A = 24'h222222;
    nacks = 0;
    for (int n = 1; n <= 55; n++) begin
      tick();
      if (bus.p0Ack || bus.p1Ack) begin
        if (nacks < 4) begin
          ack_time[nacks] = n;
          ack_port[nacks] = bus.p1Ack;
        end
        nacks++;
      end
      if (n == 1)  check("cont g0 ramA", bus.ramA, 24'h111111);
      if (n == 18) check("cont g1 ramA", bus.ramA, 24'h222222);
      if (n == 35) check("cont g2 ramA", bus.ramA, 24'h111111);
    end
    clear_reqs();
    check("cont ack count", nacks, 3);
    if (nacks >= 3) begin
      check("cont ack0 time", ack_time[0], 16);
      check("cont ack0 port", ack_port[0], 1'b0);
      check("cont ack1 time", ack_time[1], 33);
      check("cont ack1 port", ack_port[1], 1'b1);
      check("cont ack2 time", ack_time[2], 50);
      check("cont ack2 port", ack_port[2], 1'b0);
    end
    tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
